// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: ALUControl codes, ALUOp encodings, execute FSM states.
// Used by both the ALU control decoder and the alu_exec_mc execute unit.
package alu_defs_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SHL  = 4'b1000;
  localparam logic [3:0] ALU_SHR  = 4'b1001;
  localparam logic [3:0] ALU_SEQ  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  // ALUOp from the main decoder into the ALU control decoder.
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Signed overflow of r = x + y, given the three sign bits.
  function automatic logic add_ovf(input logic sx, input logic sy, input logic sr);
    return (sx == sy) && (sr != sx);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier datapath and iteration counter.
// MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_seq
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_next;
  logic               last;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;

`ifdef MUL_EARLY_TERM_EN
  // The counter bound still caps the run in case the multiplier MSB is set.
  assign last = (cnt == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last = (cnt == CW'(WIDTH - 1));
`endif

  assign done = run && last;

  // NOTE: state registers use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle ALU execute unit: 1-cycle logic/arith ops, iterative MUL with busy/done.
// MUL_EARLY_TERM_EN: MUL ends when the multiplier is exhausted; b=0 completes in 1 cycle.
module alu_exec_mc
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  alu_state_e         state;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic               sc_ill;
  logic               mul_bypass;
  logic               mul_load;
  logic               mul_run;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH-1:0]   mul_hi;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latches).
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (alu_ctrl)
      ALU_AND:  sc_res = a & b;
      ALU_OR:   sc_res = a | b;
      ALU_ADD: begin
        sc_res = sum;
        sc_ovf = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = diff;
        sc_ovf = add_ovf(a[WIDTH-1], ~b[WIDTH-1], diff[WIDTH-1]);
      end
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SHL:  sc_res = b << shamt;
      ALU_SHR:  sc_res = b >> shamt;
      ALU_SEQ:  sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      ALU_NOR:  sc_res = ~(a | b);
      ALU_NAND: sc_res = ~(a & b);
      // MUL only reaches this path for a zero multiplier, whose product is 0.
      ALU_MUL, ALU_NOP: sc_res = '0;
      default:  sc_ill = 1'b1;
    endcase
  end

`ifdef MUL_EARLY_TERM_EN
  assign mul_bypass = (b == '0);
`else
  assign mul_bypass = 1'b0;
`endif

  assign mul_load = (state == ST_IDLE) && start && (alu_ctrl == ALU_MUL) && !mul_bypass;
  assign mul_run  = (state == ST_MUL);
  assign mul_lo   = mul_prod[WIDTH-1:0];
  assign mul_hi   = mul_prod[2*WIDTH-1:WIDTH];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .run     (mul_run),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mul_load) begin
            state <= ST_MUL;
            busy  <= 1'b1;
          end else if (start) begin
            result    <= sc_res;
            result_hi <= '0;
            zero      <= (sc_res == '0);
            ovf       <= sc_ovf;
            illegal   <= sc_ill;
            done      <= 1'b1;
          end
        end
        ST_MUL: begin
          // The product register is captured on the same edge as the last iteration.
          if (mul_done) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= mul_lo;
            result_hi <= mul_hi;
            zero      <= (mul_lo == '0);
            ovf       <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Scoreboard bench for alu_exec_mc: expectations queued at issue, checked on done.
module tb_alu_exec_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, zero, ovf, illegal;
  logic [31:0] result, result_hi;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        il;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  alu_exec_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] sh);
    exp_t        e;
    int          xs, ys;
    longint      s;
    logic [63:0] p;
    xs = x;
    ys = y;
    e.res = 0; e.hi = 0; e.o = 0; e.il = 0; e.cyc = 0; e.tag = "";
    case (c)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: begin
        e.res = x + y;
        s = longint'(xs) + longint'(ys);
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0011: begin
        p = {32'b0, x} * {32'b0, y};
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      4'b0110: begin
        e.res = x - y;
        s = longint'(xs) - longint'(ys);
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.res = (xs < ys) ? 32'd1 : 32'd0;
      4'b1000: e.res = y << sh;
      4'b1001: e.res = y >> sh;
      4'b1011: e.res = (x == y) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(x | y);
      4'b1101: e.res = ~(x & y);
      4'b1111: e.res = 0;
      default: e.il = 1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Cycles from the accept edge to the completion edge (0 for a single-cycle op).
  function automatic int extra_cycles(input logic [3:0] c, input logic [31:0] y);
    if (c != 4'b0011) return 0;
`ifdef MUL_EARLY_TERM_EN
    for (int i = 31; i >= 0; i--)
      if (y[i]) return i + 1;
    return 0;
`else
    return 32;
`endif
  endfunction

  // Present one request at a negedge; the DUT must be idle so it is accepted.
  task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] sh, input bit expect_it);
    exp_t e;
    @(negedge clk);
    start = 1'b1; alu_ctrl = c; a = x; b = y; shamt = sh;
    if (expect_it) begin
      e = model(c, x, y, sh);
      e.tag = tag;
      e.cyc = cyc + 1 + extra_cycles(c, y);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    @(negedge clk);
    start = 1'b0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},    64'(busy),      64'd0);
    check({tag, "_done"},    64'(done),      64'd0);
    check({tag, "_result"},  64'(result),    64'd0);
    check({tag, "_hi"},      64'(result_hi), 64'd0);
    check({tag, "_zero"},    64'(zero),      64'd0);
    check({tag, "_ovf"},     64'(ovf),       64'd0);
    check({tag, "_illegal"}, 64'(illegal),   64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_res"},  64'(result),    64'(e.res));
        check({e.tag, "_hi"},   64'(result_hi), 64'(e.hi));
        check({e.tag, "_zero"}, 64'(zero),      64'(e.z));
        check({e.tag, "_ovf"},  64'(ovf),       64'(e.o));
        check({e.tag, "_ill"},  64'(illegal),   64'(e.il));
        check({e.tag, "_cyc"},  64'(cyc),       64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rbv;
    reset = 1'b1; start = 1'b0; alu_ctrl = 4'b0; a = 0; b = 0; shamt = 0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    issue("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1);
    drain(10);

    issue("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 1'b1);
    issue("slt_neg",  4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1);
    issue("sub_ovf",  4'b0110, 32'h80000000, 32'd1, 5'd0, 1'b1);
    issue("add_novf", 4'b0010, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1);
    drain(10);

    // Long multiply with a stray request mid-flight that must be dropped.
    issue("mul_max", 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mul_busy", 64'(busy), 64'd1);
    start = 1'b1; alu_ctrl = 4'b0010; a = 32'd1; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    drain(60);

    issue("mul_7x5", 4'b0011, 32'd7, 32'd5, 5'd0, 1'b1);
    drain(60);
    issue("mul_b0", 4'b0011, 32'd7, 32'd0, 5'd0, 1'b1);
    drain(60);

    issue("shl31",  4'b1000, 32'd0, 32'd1,          5'd31, 1'b1);
    issue("shr31",  4'b1001, 32'd0, 32'h80000000,   5'd31, 1'b1);
    issue("ill4",   4'b0100, 32'd3, 32'd4,          5'd0,  1'b1);
    issue("nop",    4'b1111, 32'd3, 32'd4,          5'd0,  1'b1);
    issue("nor",    4'b1100, 32'hF0F0F0F0, 32'h0000FFFF, 5'd0, 1'b1);
    issue("nand",   4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b1);
    issue("seq",    4'b1011, 32'h1234, 32'h1234,    5'd0,  1'b1);
    issue("and",    4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 1'b1);
    issue("or",     4'b0001, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 1'b1);
    drain(10);

    for (int i = 0; i < 24; i++) begin
      rc  = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rbv = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      issue($sformatf("rnd%0d", i), rc, ra, rbv, 5'($urandom_range(0, 31)), 1'b1);
      if (rc == 4'b0011) drain(60);
    end
    drain(60);

    // Reset in the middle of a multiply: aborted, no completion.
    issue("mul_abort", 4'b0011, 32'h12345678, 32'hFFFFFFFF, 5'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_cleared("abort");
    repeat (40) @(negedge clk);
    issue("add_after", 4'b0010, 32'd10, 32'd20, 5'd0, 1'b1);
    drain(10);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_mc.md
Name: alu_exec_mc

Overview:
Multi-cycle 32-bit ALU execute unit. It consumes the 4-bit ALUControl code produced by the ALU control decoder and is the receiving end of that interface.
- Non-multiply operations complete in 1 cycle.
- MUL uses an iterative shift-add multiplier.
- A start/busy/done handshake lets the EX stage stall the pipeline during a multiply.

Parameters:
WIDTH, 32, operand/result width (MUL iteration count equals WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
alu_ctrl  input  4  ALUControl code
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt/imm); multiplier for MUL
shamt  input  5  shift amount for SHL/SHR
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
result  output  WIDTH  result, held until next completion
result_hi  output  WIDTH  upper product half for MUL, 0 otherwise
zero  output  1  result==0, registered with result
ovf  output  1  signed overflow for ADD/SUB, 0 otherwise
illegal  output  1  unsupported code, registered with result

Behaviour:
- Reset: synchronous, active-high. All outputs go to 0; state goes to IDLE; multiply registers are cleared. Reset mid-MUL aborts the operation with no done pulse.
- Code map:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 MUL, 0110 SUB, 0111 SLT (signed).
  - 1000 SHL (b<<shamt), 1001 SHR (logical b>>shamt), 1011 SEQ, 1100 NOR, 1101 NAND.
  - 1111 NOP: result 0, illegal=0.
  - Any other code: result 0, illegal=1.
  - 1100 and 1101 always mean NOR and NAND; no SNE/SGT execution.
- Set ops return 32'd1 or 32'd0.
- ADD/SUB wrap modulo 2^WIDTH. ovf is set on signed overflow.
- States: IDLE, MUL.
  - IDLE, start=1, code≠0011: result/flags registered on that edge, done=1 next cycle (latency 1), stay IDLE, busy stays 0.
  - IDLE, start=1, code=0011: load acc=0, mcand={0,a} (2*WIDTH bits), mplier=b, cnt=0; go to MUL; busy=1.
  - MUL, each cycle:
    - if mplier[0], acc += mcand
    - mcand <<= 1; mplier >>= 1; cnt++
  - On the edge completing iteration WIDTH: result=acc[WIDTH-1:0], result_hi=acc[2W-1:W], zero per result, done=1, busy=0, return to IDLE.
  - MUL latency is WIDTH cycles (32). Product is unsigned.
- start is ignored while busy=1; no queuing.
- done is high for exactly one cycle. A new start may be accepted in the same cycle done is high.
- Back-to-back 1-cycle ops give done on consecutive cycles.
- illegal, ovf and result_hi are 0 for ops that do not define them.

Optional Feature:
MUL_EARLY_TERM_EN
- Defined: MUL finishes on the edge where the shifted mplier becomes 0. Latency = (index of MSB set in b)+1. b=0 completes as a 1-cycle op with product 0.
- Undefined: fixed WIDTH-cycle latency, even for b=0.
- Result values are identical in both builds.

Decomposition:
- Shared package/include alu_defs: the 4-bit ALUControl code constants (ALU_AND … ALU_NOP), ALUOp encodings, state encoding.
- Also used by the ALU control decoder.
- One sub-module, alu_mul_seq: the shift-add datapath and counter, with start/done to the parent FSM.
- Single-cycle ops stay combinational in the parent, registered at the output.

Test Plan:
1. Reset, then start ADD a=32'h7FFFFFFF b=1 -> done after 1 cycle, result=32'h80000000, ovf=1, zero=0.
2. start SUB a=5 b=5 -> result=0, zero=1. Then SLT a=32'hFFFFFFFF b=1 on the next cycle -> result=1; two consecutive done pulses.
3. start MUL a=32'hFFFFFFFF b=32'hFFFFFFFF -> busy for 32 cycles, done on cycle 32, result=32'h00000001, result_hi=32'hFFFFFFFE. A second start at cycle 10 is ignored.
4. With MUL_EARLY_TERM_EN: MUL a=7 b=5 -> done at cycle 3, result=35. b=0 -> done at cycle 1, result=0. Without the macro, both cases take 32 cycles.
5. SHL b=1 shamt=31 -> 32'h80000000. SHR b=32'h80000000 shamt=31 -> 1. Code 0100 -> illegal=1, result=0. Code 1111 -> illegal=0.
6. Reset asserted at cycle 15 of MUL -> next cycle busy=0, done never pulses, outputs 0. A new ADD is accepted immediately afterwards.
